// File: rtl/fwd_hazard_unit_if.sv
// Signal bundle between the execute stage and the forwarding/hazard unit.
// The master side (pipeline) drives operand and writeback information; the
// slave side (hazard unit) returns resolved operands, forward flags, stall
// and statistics.
interface fwd_hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [REG_W-1:0]  wr_regnum;
  logic              wr_en;
  logic              wr_is_load;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] ld_data;
  logic              kill;
  logic [DATA_W-1:0] A_data;
  logic [DATA_W-1:0] B_data;
  logic              fwd_a;
  logic              fwd_b;
  logic              stall;
  logic [31:0]       stall_count;
  logic [31:0]       fwd_count;

  modport master (
    output rs, rt, rs_data, rt_data, wr_regnum, wr_en, wr_is_load,
           wr_data, ld_data, kill,
    input  A_data, B_data, fwd_a, fwd_b, stall, stall_count, fwd_count
  );

  modport slave (
    input  rs, rt, rs_data, rt_data, wr_regnum, wr_en, wr_is_load,
           wr_data, ld_data, kill,
    output A_data, B_data, fwd_a, fwd_b, stall, stall_count, fwd_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Keeps a DEPTH-entry shift history of completed register writes (entry 0
// newest). Loads enter entry 0 as pending and pick up ld_data as they move
// into entry 1, so pending only ever lives in entry 0. Both operands are
// resolved combinationally against the history, newest match first; a match
// on a pending load raises stall and a bubble is captured.
// Optional macro HAZ_STATS_EN adds saturating stall/forward counters;
// without it the counter outputs are tied to zero.
module fwd_hazard_unit #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic reset,
  fwd_hazard_unit_if.slave bus
);

  // History storage
  logic              valid_q  [DEPTH];
  logic [REG_W-1:0]  regnum_q [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic              pend0_q;

  logic              valid_d  [DEPTH];
  logic [REG_W-1:0]  regnum_d [DEPTH];
  logic [DATA_W-1:0] data_d   [DEPTH];
  logic              pend0_d;

  logic              stall_w;
  logic              capture_w;
  logic              wr_valid_w;
  logic              fwd_a_w;
  logic              fwd_b_w;

  logic [REG_W-1:0]  src_reg  [2];
  logic [DATA_W-1:0] src_data [2];

  assign src_reg[0]  = bus.rs;
  assign src_reg[1]  = bus.rt;
  assign src_data[0] = bus.rs_data;
  assign src_data[1] = bus.rt_data;

  // A stalled or killed instruction leaves a bubble in entry 0.
  assign capture_w  = ~(stall_w | bus.kill);
  assign wr_valid_w = bus.wr_en & ~((ZERO_REG != 0) && (bus.wr_regnum == '0));

  assign valid_d[0]  = capture_w & wr_valid_w;
  assign regnum_d[0] = bus.wr_regnum;
  assign data_d[0]   = bus.wr_data;
  assign pend0_d     = capture_w & wr_valid_w & bus.wr_is_load;

  // Shift toward higher index; a pending load resolves on its way into entry 1.
  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign valid_d[gi]  = valid_q[gi-1];
      assign regnum_d[gi] = regnum_q[gi-1];
      if (gi == 1) begin : g_resolve
        assign data_d[gi] = pend0_q ? bus.ld_data : data_q[gi-1];
      end else begin : g_plain
        assign data_d[gi] = data_q[gi-1];
      end
    end
  endgenerate

  // History register; reset invalidates everything including a pending load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        regnum_q[i] <= '0;
        data_q[i]   <= '0;
      end
      pend0_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= valid_d[i];
        regnum_q[i] <= regnum_d[i];
        data_q[i]   <= data_d[i];
      end
      pend0_q <= pend0_d;
    end
  end

  // Per-operand lookup: scan oldest to newest so the newest match overrides.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic              hit;
      logic              pend;
      logic [DATA_W-1:0] hdata;

      // Find the lowest-index valid entry whose regnum equals the source.
      always_comb begin
        hit   = 1'b0;
        pend  = 1'b0;
        hdata = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (valid_q[i] && (regnum_q[i] == src_reg[gi]) &&
              !((ZERO_REG != 0) && (src_reg[gi] == '0))) begin
            hit   = 1'b1;
            pend  = (i == 0) && pend0_q;
            hdata = data_q[i];
          end
        end
      end
    end
  endgenerate

  assign fwd_a_w    = g_op[0].hit & ~g_op[0].pend;
  assign fwd_b_w    = g_op[1].hit & ~g_op[1].pend;
  assign stall_w    = (g_op[0].hit & g_op[0].pend) | (g_op[1].hit & g_op[1].pend);

  assign bus.fwd_a  = fwd_a_w;
  assign bus.fwd_b  = fwd_b_w;
  assign bus.stall  = stall_w;
  assign bus.A_data = fwd_a_w ? g_op[0].hdata : src_data[0];
  assign bus.B_data = fwd_b_w ? g_op[1].hdata : src_data[1];

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  // Saturating counts of stalled cycles and cycles that used a forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_w && !bus.kill && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((fwd_a_w || fwd_b_w) && !stall_w && !bus.kill &&
          (fwd_cnt_q != 32'hFFFF_FFFF))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.fwd_count   = fwd_cnt_q;
`else
  assign bus.stall_count = '0;
  assign bus.fwd_count   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (DEPTH=2, ZERO_REG=1). A table of
// per-cycle vectors covers forwarding, load-use stall, newest-wins, aging,
// zero register, kill and stall+kill; a hand sequence covers reset mid-load.
module tb_fwd_hazard_unit;

`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_sc;
  int   exp_fc;

  fwd_hazard_unit_if #(.DATA_W(32), .REG_W(5)) bus_if ();

  fwd_hazard_unit #(.DATA_W(32), .REG_W(5), .DEPTH(2), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  wr_regnum;
    logic        wr_en;
    logic        wr_is_load;
    logic [31:0] wr_data;
    logic [31:0] ld_data;
    logic        kill;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_fa;
    logic        exp_fb;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, " stall_count"}, bus_if.stall_count, STATS ? 32'(exp_sc) : 32'd0);
    chk({tag, " fwd_count"},   bus_if.fwd_count,   STATS ? 32'(exp_fc) : 32'd0);
  endtask

  task automatic drive(input vec_t v);
    bus_if.rs         = v.rs;
    bus_if.rt         = v.rt;
    bus_if.rs_data    = v.rs_data;
    bus_if.rt_data    = v.rt_data;
    bus_if.wr_regnum  = v.wr_regnum;
    bus_if.wr_en      = v.wr_en;
    bus_if.wr_is_load = v.wr_is_load;
    bus_if.wr_data    = v.wr_data;
    bus_if.ld_data    = v.ld_data;
    bus_if.kill       = v.kill;
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    exp_sc = 0;
    exp_fc = 0;

    //          rs rt rs_data rt_data   wreg en ld wr_data   ld_data   kill  expA       expB    fa fb st
    vecs[0]  = '{8, 0, 32'h0,  32'h0,   8,  1, 0, 32'h11,   32'h0,    0, 32'h0,     32'h0,    0, 0, 0};
    vecs[1]  = '{8, 1, 32'h0,  32'h5,   9,  1, 1, 32'hDEAD, 32'h0,    0, 32'h11,    32'h5,    1, 0, 0};
    vecs[2]  = '{8, 9, 32'h0,  32'h3,   7,  1, 0, 32'h77,   32'hCAFE, 0, 32'h11,    32'h3,    1, 0, 1};
    vecs[3]  = '{7, 9, 32'h9,  32'h0,   5,  1, 0, 32'hA,    32'h1234, 0, 32'h9,     32'hCAFE, 0, 1, 0};
    vecs[4]  = '{5, 9, 32'h0,  32'h66,  5,  1, 0, 32'hB,    32'h0,    0, 32'hA,     32'h66,   1, 0, 0};
    vecs[5]  = '{5, 0, 32'h0,  32'h0,   0,  0, 0, 32'h0,    32'h0,    0, 32'hB,     32'h0,    1, 0, 0};
    vecs[6]  = '{5, 0, 32'h7,  32'h0,   0,  0, 0, 32'h0,    32'h0,    0, 32'hB,     32'h0,    1, 0, 0};
    vecs[7]  = '{5, 0, 32'h7,  32'h0,   0,  1, 0, 32'hFF,   32'h0,    0, 32'h7,     32'h0,    0, 0, 0};
    vecs[8]  = '{0, 0, 32'h0,  32'h0,   3,  1, 0, 32'h44,   32'h0,    1, 32'h0,     32'h0,    0, 0, 0};
    vecs[9]  = '{3, 0, 32'h1,  32'h0,   4,  1, 1, 32'h99,   32'h0,    0, 32'h1,     32'h0,    0, 0, 0};
    vecs[10] = '{4, 3, 32'h20, 32'h2,   6,  1, 0, 32'h66,   32'hBEEF, 1, 32'h20,    32'h2,    0, 0, 1};
    vecs[11] = '{4, 0, 32'h0,  32'h0,   0,  0, 0, 32'h0,    32'h0,    0, 32'hBEEF,  32'h0,    1, 0, 0};

    idle = '{0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0};

    // Reset state
    reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset A_data", bus_if.A_data, 32'h0);
    chk("reset B_data", bus_if.B_data, 32'h0);
    chk("reset flags", {29'd0, bus_if.fwd_a, bus_if.fwd_b, bus_if.stall}, 32'h0);
    chk_counters("reset");
    bus_if.rs_data = 32'h55;
    #1;
    chk("reset A passthrough", bus_if.A_data, 32'h55);
    bus_if.rs_data = 32'h0;
    reset = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d A_data", i), bus_if.A_data, vecs[i].exp_a);
      chk($sformatf("v%0d B_data", i), bus_if.B_data, vecs[i].exp_b);
      chk($sformatf("v%0d fwd_a", i), {31'd0, bus_if.fwd_a}, {31'd0, vecs[i].exp_fa});
      chk($sformatf("v%0d fwd_b", i), {31'd0, bus_if.fwd_b}, {31'd0, vecs[i].exp_fb});
      chk($sformatf("v%0d stall", i), {31'd0, bus_if.stall}, {31'd0, vecs[i].exp_stall});
      chk_counters($sformatf("v%0d", i));
      $display("vec %0d rs=%0d rt=%0d A=0x%08h B=0x%08h fa=%0b fb=%0b stall=%0b",
               i, vecs[i].rs, vecs[i].rt, bus_if.A_data, bus_if.B_data,
               bus_if.fwd_a, bus_if.fwd_b, bus_if.stall);
      if (vecs[i].exp_stall && !vecs[i].kill) exp_sc++;
      if ((vecs[i].exp_fa || vecs[i].exp_fb) && !vecs[i].exp_stall && !vecs[i].kill) exp_fc++;
    end

    // Counters after the last table edge
    @(posedge clk);
    #1;
    drive(idle);
    chk_counters("table end");

    // Reset pulsed while a load to r4 is pending
    bus_if.wr_regnum  = 5'd4;
    bus_if.wr_en      = 1'b1;
    bus_if.wr_is_load = 1'b1;
    @(posedge clk);
    #1;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_is_load = 1'b0;
    bus_if.rs         = 5'd4;
    bus_if.rs_data    = 32'h2;
    #1;
    chk("preload stall", {31'd0, bus_if.stall}, 32'd1);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_sc = 0;
    exp_fc = 0;
    bus_if.ld_data = 32'h5555;
    @(negedge clk);
    chk("rst-load stall", {31'd0, bus_if.stall}, 32'd0);
    chk("rst-load A_data", bus_if.A_data, 32'h2);
    chk_counters("rst-load");
    $display("reset mid-load: stall=%0b A=0x%08h", bus_if.stall, bus_if.A_data);
    @(posedge clk);
    #1;
    chk("post-edge A_data", bus_if.A_data, 32'h2);
    chk("post-edge fwd_a", {31'd0, bus_if.fwd_a}, 32'd0);
    chk_counters("post-edge");
    $display("after ld edge: A=0x%08h fwd_a=%0b", bus_if.A_data, bus_if.fwd_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
